// File: rtl/bldc_cmd_pkg.sv
// Shared encodings for the BLDC command dispatcher: command modes, channel states, drive bits.
package bldc_cmd_pkg;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'b00,
        MODE_CW    = 2'b01,
        MODE_CCW   = 2'b10,
        MODE_BRAKE = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RUN_CW,
        ST_RUN_CCW,
        ST_BRAKE,
        ST_DEAD
    } chan_state_e;

    localparam int unsigned DRV_CW    = 0;
    localparam int unsigned DRV_CCW   = 1;
    localparam int unsigned DRV_BRAKE = 2;
    localparam int unsigned DRV_W     = 3;

    // One-hot drive field with only the given bit set.
    function automatic logic [DRV_W-1:0] drv_bit(input int unsigned idx);
        return DRV_W'(1) << idx;
    endfunction

endpackage

// File: rtl/bldc_chan_interlock.sv
// One motor channel: run/brake FSM with a dead-time interlock on CW<->CCW reversal.
module bldc_chan_interlock
    import bldc_cmd_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_e            mode_i,
    input  logic             hit_i,
    input  logic             estop_i,
    output logic [DRV_W-1:0] drive_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(DEAD_CYCLES + 1);

    chan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_ccw_q;
    logic [DRV_W-1:0] drive_q;
    logic             busy_q;

    // estop outranks dead-time expiry, which outranks new commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            pend_ccw_q <= 1'b0;
            drive_q    <= '0;
            busy_q     <= 1'b0;
        end else if (estop_i) begin
            state_q    <= ST_BRAKE;
            cnt_q      <= '0;
            pend_ccw_q <= 1'b0;
            drive_q    <= drv_bit(DRV_BRAKE);
            busy_q     <= 1'b0;
        end else if (state_q == ST_DEAD) begin
            if (cnt_q == CNT_W'(1)) begin
                state_q    <= pend_ccw_q ? ST_RUN_CCW : ST_RUN_CW;
                drive_q    <= pend_ccw_q ? drv_bit(DRV_CCW) : drv_bit(DRV_CW);
                busy_q     <= 1'b0;
                cnt_q      <= '0;
                pend_ccw_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (hit_i) begin
            case (mode_i)
                MODE_STOP: begin
                    state_q <= ST_OFF;
                    drive_q <= '0;
                end
                MODE_BRAKE: begin
                    state_q <= ST_BRAKE;
                    drive_q <= drv_bit(DRV_BRAKE);
                end
                MODE_CW: begin
                    if (state_q == ST_RUN_CCW) begin
                        state_q    <= ST_DEAD;
                        cnt_q      <= CNT_W'(DEAD_CYCLES);
                        pend_ccw_q <= 1'b0;
                        drive_q    <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_RUN_CW;
                        drive_q <= drv_bit(DRV_CW);
                    end
                end
                MODE_CCW: begin
                    if (state_q == ST_RUN_CW) begin
                        state_q    <= ST_DEAD;
                        cnt_q      <= CNT_W'(DEAD_CYCLES);
                        pend_ccw_q <= 1'b1;
                        drive_q    <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_RUN_CCW;
                        drive_q <= drv_bit(DRV_CCW);
                    end
                end
                default: ;
            endcase
        end
    end

    assign drive_o = drive_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/bldc_cmd_dispatch.sv
// Byte-command dispatcher: valid/ready intake, reserved-bit check and mask fan-out to N interlocked channels.
module bldc_cmd_dispatch
    import bldc_cmd_pkg::*;
#(
    parameter int unsigned NUM_MOTORS  = 4,
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  cmd_data,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        estop,
    output logic [DRV_W*NUM_MOTORS-1:0] drive,
    output logic [NUM_MOTORS-1:0]       busy,
    output logic                        cmd_err
);

    // Bits above the motor mask; empty when all six mask bits are in use.
    localparam logic [7:0] RSVD_MASK = 8'(16'h00FF << (NUM_MOTORS + 2));

    logic                  accept_c;
    logic                  rsvd_bad_c;
    logic [NUM_MOTORS-1:0] mask_c;
    mode_e                 mode_c;
    logic                  cmd_err_q;

    assign cmd_ready  = ~estop & ~|busy;
    assign accept_c   = cmd_valid & cmd_ready;
    assign rsvd_bad_c = |(cmd_data & RSVD_MASK);
    assign mask_c     = cmd_data[NUM_MOTORS+1:2];
    assign mode_c     = mode_e'(cmd_data[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= accept_c & rsvd_bad_c;
        end
    end

    assign cmd_err = cmd_err_q;

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_chan
        logic hit_c;
        assign hit_c = accept_c & ~rsvd_bad_c & mask_c[i];

        bldc_chan_interlock #(
            .DEAD_CYCLES(DEAD_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .mode_i  (mode_c),
            .hit_i   (hit_c),
            .estop_i (estop),
            .drive_o (drive[DRV_W*i +: DRV_W]),
            .busy_o  (busy[i])
        );

        a_drive_onehot0: assert property (@(posedge clk) disable iff (rst)
            $onehot0(drive[DRV_W*i +: DRV_W]));
    end

endmodule

// File: tb/tb_bldc_cmd_dispatch.sv
// Bench for bldc_cmd_dispatch: directed vector table, multi-cycle sequences and random traffic vs. a reference model.
module tb_bldc_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d_a, d_b;
    logic        v_a, v_b, e_a, e_b;
    logic        r_a, r_b, err_a, err_b;
    logic [11:0] drv_a;
    logic [17:0] drv_b;
    logic [3:0]  busy_a;
    logic [5:0]  busy_b;

    always #5 clk = ~clk;

    bldc_cmd_dispatch #(.NUM_MOTORS(4), .DEAD_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .cmd_data(d_a), .cmd_valid(v_a), .cmd_ready(r_a),
        .estop(e_a), .drive(drv_a), .busy(busy_a), .cmd_err(err_a));

    bldc_cmd_dispatch #(.NUM_MOTORS(6), .DEAD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .cmd_data(d_b), .cmd_valid(v_b), .cmd_ready(r_b),
        .estop(e_b), .drive(drv_b), .busy(busy_b), .cmd_err(err_b));

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    // Model: channel state 0=OFF 1=CW 2=CCW 3=BRAKE; a reversal is a pending target with a release edge.
    int m_st   [2][6];
    bit m_pend [2][6];
    int m_tgt  [2][6];
    int m_rel  [2][6];
    bit m_err  [2];

    function automatic int nm_of(input int u);
        return (u == 0) ? 4 : 6;
    endfunction

    function automatic int dc_of(input int u);
        return (u == 0) ? 8 : 1;
    endfunction

    function automatic bit any_pend(input int u);
        for (int i = 0; i < 6; i++) if (m_pend[u][i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] exp_drv(input int u);
        logic [17:0] r;
        logic [2:0]  f;
        r = '0;
        for (int i = 0; i < nm_of(u); i++) begin
            case (m_st[u][i])
                1:       f = 3'b001;
                2:       f = 3'b010;
                3:       f = 3'b100;
                default: f = 3'b000;
            endcase
            if (m_pend[u][i]) f = 3'b000;
            r[3*i +: 3] = f;
        end
        return r;
    endfunction

    function automatic logic [5:0] exp_busy(input int u);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[i] = m_pend[u][i];
        return r;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_err[u] = 1'b0;
            for (int i = 0; i < 6; i++) begin
                m_st[u][i] = 0; m_pend[u][i] = 1'b0; m_tgt[u][i] = 0; m_rel[u][i] = 0;
            end
        end
    endtask

    task automatic model_edge(input int u, input logic [7:0] d, input bit v, input bit e);
        bit rdy, acc, rsv;
        int md;
        rdy = !e && !any_pend(u);
        acc = v && rdy;
        rsv = (int'(d) >> (nm_of(u) + 2)) != 0;
        m_err[u] = acc && rsv;
        if (e) begin
            for (int i = 0; i < 6; i++) begin
                m_st[u][i] = 3; m_pend[u][i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 6; i++)
                if (m_pend[u][i] && cyc >= m_rel[u][i]) begin
                    m_st[u][i] = m_tgt[u][i]; m_pend[u][i] = 1'b0;
                end
            if (acc && !rsv) begin
                md = int'(d) & 3;
                for (int i = 0; i < nm_of(u); i++) begin
                    if (d[i+2]) begin
                        if (md == 0 || md == 3) m_st[u][i] = md;
                        else if (m_st[u][i] == 3 - md) begin
                            m_pend[u][i] = 1'b1; m_tgt[u][i] = md; m_rel[u][i] = cyc + dc_of(u);
                        end else m_st[u][i] = md;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all();
        logic [17:0] ed;
        logic [5:0]  eb;
        ed = exp_drv(0); eb = exp_busy(0);
        chk("drive_a", 32'(drv_a), 32'(ed[11:0]));
        chk("busy_a",  32'(busy_a), 32'(eb[3:0]));
        chk("err_a",   32'(err_a), 32'(m_err[0]));
        chk("ready_a", 32'(r_a), 32'(!e_a && !any_pend(0)));
        ed = exp_drv(1); eb = exp_busy(1);
        chk("drive_b", 32'(drv_b), 32'(ed));
        chk("busy_b",  32'(busy_b), 32'(eb));
        chk("err_b",   32'(err_b), 32'(m_err[1]));
        chk("ready_b", 32'(r_b), 32'(!e_b && !any_pend(1)));
    endtask

    // Model the coming edge from the current inputs, take the edge, compare just after it.
    task automatic step();
        cyc++;
        model_edge(0, d_a, v_a, e_a);
        model_edge(1, d_b, v_b, e_b);
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          valid;
        bit          estop;
        logic [11:0] drv;
        bit          err;
        bit          rdy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{8'h05, 1'b1, 1'b0, 12'h001, 1'b0, 1'b1};
        tbl[1] = '{8'h3F, 1'b1, 1'b0, 12'h924, 1'b0, 1'b1};
        tbl[2] = '{8'h3D, 1'b1, 1'b0, 12'h249, 1'b0, 1'b1};
        tbl[3] = '{8'hC5, 1'b1, 1'b0, 12'h249, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 12'h249, 1'b0, 1'b1};
        tbl[5] = '{8'h01, 1'b1, 1'b0, 12'h249, 1'b0, 1'b1};
        tbl[6] = '{8'h0C, 1'b1, 1'b0, 12'h240, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 1'b0, 1'b1, 12'h924, 1'b0, 1'b0};
        tbl[8] = '{8'h00, 1'b0, 1'b0, 12'h924, 1'b0, 1'b1};
        tbl[9] = '{8'h39, 1'b1, 1'b0, 12'h24C, 1'b0, 1'b1};

        rst = 1'b1;
        d_a = '0; v_a = 1'b0; e_a = 1'b0;
        d_b = '0; v_b = 1'b0; e_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drive_a", 32'(drv_a), 32'h0);
        chk("rst_busy_a",  32'(busy_a), 32'h0);
        chk("rst_err_a",   32'(err_a), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_ready_a", 32'(r_a), 32'h1);

        // Directed single-cycle vectors on the 4-channel unit.
        for (int k = 0; k < 10; k++) begin
            d_a = tbl[k].data; v_a = tbl[k].valid; e_a = tbl[k].estop;
            step();
            chk($sformatf("tbl%0d_drive", k), 32'(drv_a), 32'(tbl[k].drv));
            chk($sformatf("tbl%0d_err", k),   32'(err_a), 32'(tbl[k].err));
            chk($sformatf("tbl%0d_ready", k), 32'(r_a),   32'(tbl[k].rdy));
        end
        v_a = 1'b0; e_a = 1'b0;

        // Reversal on M1 with an M2 command stalled behind the dead time.
        d_a = 8'h08; v_a = 1'b1; step();
        d_a = 8'h05; step();
        chk("rev_m1_cw", 32'(drv_a[2:0]), 32'h1);
        d_a = 8'h06; step();
        chk("rev_dead0_drive", 32'(drv_a[2:0]), 32'h0);
        chk("rev_dead0_busy",  32'(busy_a[0]), 32'h1);
        d_a = 8'h09;
        for (int j = 1; j < 8; j++) begin
            step();
            chk($sformatf("rev_dead%0d_drive", j), 32'(drv_a[2:0]), 32'h0);
            chk($sformatf("rev_dead%0d_ready", j), 32'(r_a), 32'h0);
        end
        step();
        chk("rev_done_ccw",   32'(drv_a[2:0]), 32'h2);
        chk("rev_done_busy",  32'(busy_a), 32'h0);
        chk("rev_m2_stalled", 32'(drv_a[5:3]), 32'h0);
        step();
        chk("rev_m2_accepted", 32'(drv_a[5:3]), 32'h1);
        v_a = 1'b0;

        // estop arriving with M2's dead counter at 4 aborts the reversal.
        d_a = 8'h0A; v_a = 1'b1; step();
        v_a = 1'b0;
        repeat (4) step();
        chk("est_pre_busy", 32'(busy_a[1]), 32'h1);
        e_a = 1'b1; step();
        chk("est_drive", 32'(drv_a), 32'h924);
        chk("est_busy",  32'(busy_a), 32'h0);
        chk("est_ready", 32'(r_a), 32'h0);
        e_a = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("est_hold%0d", j), 32'(drv_a), 32'h924);
        end

        // Six channels with a single dead cycle, then asynchronous reset mid-run.
        d_b = 8'hFD; v_b = 1'b1; step();
        chk("b_all_cw", 32'(drv_b), 32'h09249);
        d_b = 8'hFE; step();
        v_b = 1'b0;
        chk("b_dead_drive", 32'(drv_b), 32'h0);
        chk("b_dead_busy",  32'(busy_b), 32'h3F);
        step();
        chk("b_all_ccw", 32'(drv_b), 32'h12492);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_drive_b", 32'(drv_b), 32'h0);
        chk("arst_busy_b",  32'(busy_b), 32'h0);
        chk("arst_drive_a", 32'(drv_a), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_ready_b", 32'(r_b), 32'h1);

        // Random traffic against the model on both units.
        for (int n = 0; n < 3000; n++) begin
            d_a = {(($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00), 4'($urandom), 2'($urandom)};
            v_a = ($urandom_range(0, 3) != 0);
            e_a = ($urandom_range(0, 59) == 0);
            d_b = 8'($urandom);
            v_b = ($urandom_range(0, 3) != 0);
            e_b = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/bldc_cmd_dispatch.md
Name: bldc_cmd_dispatch

Overview:
- Sequential, parametrised successor to the 8-bit motor command decoder.
- Accepts byte commands from the UART RX path through a valid/ready handshake.
- Decodes each command into registered one-hot drive requests {brake, ccw, cw} for NUM_MOTORS BLDC commutation channels.
- Enforces a per-channel dead-time interlock on CW<->CCW reversal, plus a global emergency brake.

Parameters:
- NUM_MOTORS, 4, number of motor channels; legal range 1..6.
- DEAD_CYCLES, 8, coast cycles inserted on direction reversal; must be >= 1.
- CNT_W, $clog2(DEAD_CYCLES+1), width of the dead-time counter (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_data  in  8  command byte; [1:0] mode (00 STOP, 01 CW, 10 CCW, 11 BRAKE), [NUM_MOTORS+1:2] motor mask, [7:NUM_MOTORS+2] reserved, must be 0
- cmd_valid  in  1  command byte present
- cmd_ready  out  1  block can accept a command
- estop  in  1  level-sensitive emergency brake, sampled on clk
- drive  out  3*NUM_MOTORS  per channel i, bits [3i+2:3i] = {brake, ccw, cw}, one-hot or all-zero
- busy  out  NUM_MOTORS  channel i is in its dead-time state
- cmd_err  out  1  one-cycle pulse when an accepted byte has nonzero reserved bits

Behaviour:
- Reset values: drive=0 (all channels OFF), busy=0, cmd_err=0, dead-time counters=0. cmd_ready=1 once rst deasserts (when estop=0).
- cmd_ready = ~estop & ~|busy. This is combinational from registered state and estop; it does not depend on cmd_valid.
- Accept happens on any edge where cmd_valid & cmd_ready. Non-accepted bytes have no effect.
- If an accepted byte has nonzero reserved bits: the byte is dropped (no channel changes) and cmd_err=1 for the following cycle.
- A mask of zero is accepted and is a no-op.
- Per-channel FSM states: OFF, RUN_CW, RUN_CCW, BRAKE, DEAD. Only channels with their mask bit set react.
  - STOP -> OFF
  - BRAKE -> BRAKE
  - CW from OFF, BRAKE or RUN_CW -> RUN_CW
  - CCW from OFF, BRAKE or RUN_CCW -> RUN_CCW
  - CW from RUN_CCW, or CCW from RUN_CW -> DEAD. On entry, load counter=DEAD_CYCLES and latch the pending direction.
- Latency: outputs are registered. The new drive value is visible immediately after the accepting edge (1 cycle).
- DEAD state:
  - drive=000 and busy=1.
  - The counter decrements once per edge.
  - On the edge where the counter is 1, the channel enters the pending RUN state and busy clears.
  - Reversal accepted at edge k: drive=000 for edges k..k+DEAD_CYCLES-1; the new direction appears at edge k+DEAD_CYCLES.
- Re-commanding the current state leaves it unchanged with no glitch.
- While any channel is busy, cmd_ready=0, so all commands (including ones to other channels) are stalled.
- estop has the highest priority. Each edge estop=1 forces every channel to BRAKE, clears counters, pending directions and busy, and holds cmd_ready=0.
- After estop is released, channels stay in BRAKE until commanded.
- estop arriving mid-DEAD aborts the reversal; the channel goes to BRAKE on that edge.
- Reset mid-operation immediately returns everything to the reset values, asynchronously.
- Invariant: each 3-bit drive field is never more than one-hot. Checked by an assertion.

Decomposition:
- Package bldc_cmd_pkg holds:
  - mode encodings MODE_STOP, MODE_CW, MODE_CCW, MODE_BRAKE
  - the state enum for the per-channel FSM
  - drive bit index constants DRV_CW=0, DRV_CCW=1, DRV_BRAKE=2
- Sub-module bldc_chan_interlock implements one channel: FSM, dead counter and pending direction.
  - Inputs: mode, hit, estop.
  - Outputs: drive[2:0], busy.
  - The top level does handshake, reserved-bit check and mask fan-out, and generates NUM_MOTORS instances.

Test Plan:
- Reset then byte 8'h05 (M1 CW) -> drive[2:0]=001 after the accept edge; cmd_ready stays 1; other fields 000.
- M1 in RUN_CW, send 8'h06 (M1 CCW), DEAD_CYCLES=8 -> busy[0]=1 and drive[2:0]=000 for 8 edges, then 010. cmd_ready=0 throughout, so 8'h09 (M2 CW) held valid is stalled until busy clears, then accepted.
- 8'h3F (mask 1111, BRAKE) -> drive=12'b100100100100. Then 8'h3D (all CW) -> drive=12'b001001001001 with no dead time.
- Byte 8'hC5 (reserved bits set) -> accepted, cmd_err pulses for exactly 1 cycle, drive unchanged.
- Start a reversal on M2, assert estop at dead count 4 -> all fields 100, busy=0, cmd_ready=0. Release estop -> fields remain 100 until a new command.
- NUM_MOTORS=6, DEAD_CYCLES=1: byte 8'hFD (all CW), then 8'hFE (all CCW) -> one 000 cycle, then all 010. Assert rst mid-run -> drive=0 asynchronously.
